// File: rtl/chip_frm.sv
// chip_frm: buffers chip samples {sel, data} in a FIFO and packs them into
// checksummed byte frames for a UART transmitter.
//
// Frame: A5, {00,dev_id}, len, len x (SEL, DHI, DLO), CSUM.
// CSUM covers DEV..last DLO (SYNC excluded). It is a modulo-256 sum, or a
// CRC-8 (poly 0x07, init 0) when CHIP_FRM_CRC_EN is defined. Frame length and
// timing are the same in both builds.
//
// Ports:
//   clk_sys   system clock (single domain)
//   rst       synchronous active-high reset
//   pluse_us  one-cycle strobe per microsecond (idle timeout time base)
//   dev_id    device id for the frame header
//   chip_d    sample data
//   chip_vld  sample valid
//   chip_sel  sample path select tag
//   chip_rdy  registered space-available flag to the upstream stage
//   tx_byte   byte to the UART
//   tx_vld    tx_byte valid, held until tx_done
//   tx_done   UART accepted the current byte
//   ovf       sticky: a sample was dropped on a full FIFO
module chip_frm #(
  parameter int DEPTH   = 64,
  parameter int FRM_LEN = 16,
  parameter int TMO_US  = 1000
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        pluse_us,
  input  logic [5:0]  dev_id,
  input  logic [15:0] chip_d,
  input  logic        chip_vld,
  input  logic [6:0]  chip_sel,
  output logic        chip_rdy,
  output logic [7:0]  tx_byte,
  output logic        tx_vld,
  input  logic        tx_done,
  output logic        ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TMO_US + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] RDY_C   = CW'(DEPTH - 3);
  localparam logic [CW-1:0] FRM_C   = CW'(FRM_LEN);
  localparam logic [TW-1:0] TMO_C   = TW'(TMO_US);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_DEV, S_LEN, S_SEL, S_DHI, S_DLO, S_CSUM
  } state_t;

  state_t          state_q;
  logic [22:0]     mem [DEPTH];
  logic [22:0]     rd_data_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q, rd_addr;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tcnt_q;
  logic [7:0]      len_q, smp_q, csum_q, len_d;
  logic [5:0]      dev_q;
  logic            tx_vld_q, chip_rdy_q, ovf_q;
  logic            wr_en, pop, accept, start;

  function automatic logic [7:0] csum_upd(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
`ifdef CHIP_FRM_CRC_EN
    r = c ^ b;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
`else
    r = c + b;
`endif
    return r;
  endfunction

  assign accept = tx_vld_q && tx_done;
  assign pop    = accept && (state_q == S_DLO);
  assign wr_en  = chip_vld && (cnt_q < DEPTH_C);
  assign start  = (state_q == S_IDLE) &&
                  ((cnt_q >= FRM_C) || ((cnt_q != '0) && (tcnt_q == TMO_C)));
  assign len_d  = (cnt_q >= FRM_C) ? 8'(FRM_LEN) : 8'(cnt_q);

  // Read address looks one entry ahead on a pop so the next sample's word
  // is already in rd_data_q when SEL is presented on the following cycle.
  assign rd_addr = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!wr_en && pop) cnt_d = cnt_q - 1'b1;
  end

  // Sample storage: plain array with registered read, no reset.
  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[wr_ptr_q] <= {chip_sel, chip_d};
    rd_data_q <= mem[rd_addr];
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      chip_rdy_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      rd_ptr_q   <= rd_addr;
      cnt_q      <= cnt_d;
      // Two entries of slack cover samples already issued before rdy drops.
      chip_rdy_q <= (cnt_d <= RDY_C);
      if (chip_vld && (cnt_q == DEPTH_C)) ovf_q <= 1'b1;
    end
  end

  // Idle timeout: only runs while data sits in the FIFO with no new writes.
  always_ff @(posedge clk_sys) begin
    if (rst || wr_en || start || (cnt_q == '0)) tcnt_q <= '0;
    else if (pluse_us && (tcnt_q != TMO_C))     tcnt_q <= tcnt_q + 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tx_vld_q <= 1'b0;
      len_q    <= '0;
      smp_q    <= '0;
      csum_q   <= '0;
      dev_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_SYNC;
            tx_vld_q <= 1'b1;
            len_q    <= len_d;
            smp_q    <= len_d;
            csum_q   <= '0;
            dev_q    <= dev_id;
          end
        end
        default: begin
          if (accept) begin
            if (state_q != S_SYNC && state_q != S_CSUM) csum_q <= csum_upd(csum_q, tx_byte);
            case (state_q)
              S_SYNC: state_q <= S_DEV;
              S_DEV:  state_q <= S_LEN;
              S_LEN:  state_q <= S_SEL;
              S_SEL:  state_q <= S_DHI;
              S_DHI:  state_q <= S_DLO;
              S_DLO: begin
                smp_q   <= smp_q - 1'b1;
                state_q <= (smp_q == 8'd1) ? S_CSUM : S_SEL;
              end
              default: begin
                state_q  <= S_IDLE;
                tx_vld_q <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

  // Byte mux selects among registers only; the value is stable for as long
  // as the state is held.
  always_comb begin
    tx_byte = 8'h00;
    case (state_q)
      S_SYNC: tx_byte = 8'hA5;
      S_DEV:  tx_byte = {2'b00, dev_q};
      S_LEN:  tx_byte = len_q;
      S_SEL:  tx_byte = {1'b0, rd_data_q[22:16]};
      S_DHI:  tx_byte = rd_data_q[15:8];
      S_DLO:  tx_byte = rd_data_q[7:0];
      S_CSUM: tx_byte = csum_q;
      default: tx_byte = 8'h00;
    endcase
  end

  assign tx_vld   = tx_vld_q;
  assign chip_rdy = chip_rdy_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_chip_frm.sv
// Randomized self-checking bench for chip_frm (DEPTH=8, FRM_LEN=8, TMO_US=4).
// A reference model keeps a queue of accepted samples and parses the byte
// stream frame by frame against the framing rules.
module tb_chip_frm;
  localparam int DEPTH = 8, FRM_LEN = 8, TMO_US = 4;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        pluse_us;
  logic [5:0]  dev_id = 6'd5;
  logic [15:0] chip_d = '0;
  logic        chip_vld = 1'b0;
  logic [6:0]  chip_sel = '0;
  logic        chip_rdy;
  logic [7:0]  tx_byte;
  logic        tx_vld;
  logic        tx_done;
  logic        ovf;

  logic pulse_en = 1'b1, pulse_man = 1'b0, pulse_gen;
  bit   txd_en = 1'b1;
  int   txd_max = 0;
  int   total = 0, bad = 0;

  assign pluse_us = pulse_en ? pulse_gen : pulse_man;

  chip_frm #(.DEPTH(DEPTH), .FRM_LEN(FRM_LEN), .TMO_US(TMO_US)) dut (
    .clk_sys(clk_sys), .rst(rst), .pluse_us(pluse_us), .dev_id(dev_id),
    .chip_d(chip_d), .chip_vld(chip_vld), .chip_sel(chip_sel),
    .chip_rdy(chip_rdy), .tx_byte(tx_byte), .tx_vld(tx_vld),
    .tx_done(tx_done), .ovf(ovf)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_upd(input logic [7:0] c, input logic [7:0] b);
`ifdef CHIP_FRM_CRC_EN
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
`else
    return c + b;
`endif
  endfunction

  // Microsecond strobe: one pulse every 10 cycles.
  initial begin
    int pcnt;
    pcnt = 0;
    pulse_gen = 1'b0;
    forever begin
      @(posedge clk_sys); #1;
      pcnt++;
      pulse_gen = (pcnt % 10 == 0);
    end
  end

  // UART side: accept each byte after a random delay, plus stray pulses while idle.
  initial begin
    int wl;
    wl = 0;
    tx_done = 1'b0;
    forever begin
      @(posedge clk_sys); #1;
      tx_done = 1'b0;
      if (txd_en) begin
        if (tx_vld) begin
          if (wl == 0) begin
            tx_done = 1'b1;
            wl = $urandom_range(0, txd_max);
          end else wl--;
        end else if ($urandom_range(0, 7) == 0) tx_done = 1'b1;
      end
    end
  end

  // Reference model, evaluated on the falling edge for the coming rising edge.
  logic [22:0] mq[$];
  int   flens[$];
  bit   exp_ovf = 0, prev_vld = 0, prev_done = 0, prev_rst = 1, gap = 0;
  logic [7:0] prev_byte = '0, ccsum = '0;
  int   fidx = -1, flen_exp = 0, saved_cnt = 0, nbytes = 0, last_nbytes = 0;

  always @(negedge clk_sys) begin : mon
    logic [7:0]  eb;
    logic [22:0] s;
    int          k, cnt_now;
    string       tg;
    if (rst) begin
      mq.delete();
      exp_ovf = 0; fidx = -1; gap = 0; saved_cnt = 0;
      prev_vld = 0; prev_done = 0;
    end else begin
      if (!prev_rst) begin
        chk("rdy", chip_rdy, (mq.size() <= DEPTH - 3));
        chk("ovf", ovf, exp_ovf);
        if (prev_vld && !prev_done) begin
          chk("hold_vld", tx_vld, 1);
          chk("hold_byte", tx_byte, prev_byte);
        end
        if (gap) chk("gap_vld", tx_vld, 0);
      end
      gap = 0;
      if (tx_vld && !prev_vld) begin
        fidx = 0;
        flen_exp = (saved_cnt < FRM_LEN) ? saved_cnt : FRM_LEN;
        ccsum = '0;
        nbytes = 0;
      end
      cnt_now = mq.size();
      if (tx_vld && tx_done && fidx >= 0) begin
        k = fidx - 3;
        s = (mq.size() > 0) ? mq[0] : '0;
        if (fidx == 0)      begin eb = 8'hA5; tg = "sync"; end
        else if (fidx == 1) begin eb = {2'b00, dev_id}; tg = "dev"; end
        else if (fidx == 2) begin eb = flen_exp[7:0]; tg = "len"; end
        else if (k < 3 * flen_exp) begin
          case (k % 3)
            0:       begin eb = {1'b0, s[22:16]}; tg = "sel"; end
            1:       begin eb = s[15:8]; tg = "dhi"; end
            default: begin eb = s[7:0]; tg = "dlo"; end
          endcase
        end else begin eb = ccsum; tg = "csum"; end
        chk(tg, tx_byte, eb);
        nbytes++;
        if (fidx >= 1 && k < 3 * flen_exp) ccsum = ref_upd(ccsum, eb);
        if (fidx >= 3 && k < 3 * flen_exp && k % 3 == 2 && mq.size() > 0) void'(mq.pop_front());
        if (fidx >= 3 && k == 3 * flen_exp) begin
          fidx = -1; gap = 1;
          flens.push_back(flen_exp);
          last_nbytes = nbytes;
        end else fidx++;
      end
      if (chip_vld) begin
        if (cnt_now < DEPTH) mq.push_back({chip_sel, chip_d});
        else exp_ovf = 1;
      end
      saved_cnt = cnt_now;
      prev_vld = tx_vld; prev_done = tx_done; prev_byte = tx_byte;
    end
    prev_rst = rst;
  end

  task automatic cyc();
    @(posedge clk_sys); #1;
  endtask

  task automatic put(input logic [6:0] s, input logic [15:0] d);
    chip_sel = s; chip_d = d; chip_vld = 1'b1;
    cyc();
    chip_vld = 1'b0;
  endtask

  task automatic put_rdy(input logic [6:0] s, input logic [15:0] d);
    int n;
    n = 0;
    while (!chip_rdy && n < 2000) begin cyc(); n++; end
    chk("wait_rdy", (n < 2000), 1);
    put(s, d);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(fidx == -1 && mq.size() == 0 && !tx_vld) && n < 20000) begin cyc(); n++; end
    chk(tag, (n < 20000), 1);
    cyc();
  endtask

  task automatic wait_vld(input string tag);
    int n;
    n = 0;
    while (!tx_vld && n < 500) begin cyc(); n++; end
    chk(tag, (n < 500), 1);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) cyc();
    #1;
    chk("rst_rdy", chip_rdy, 0);
    chk("rst_vld", tx_vld, 0);
    chk("rst_byte", tx_byte, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    cyc(); #1;
    chk("rdy_after_rst", chip_rdy, 1);

    // Full frame, no stall
    for (int i = 0; i < FRM_LEN; i++) put(7'd3, 16'h0100 + 16'(i));
    wait_idle("idle_full");
    chk("full_len", flens.size() > 0 ? flens[$] : -1, FRM_LEN);

    // Timeout flush
    pulse_en = 1'b0;
    for (int i = 0; i < 3; i++) put(7'd4, 16'($urandom));
    for (int p = 1; p <= 4; p++) begin
      repeat (9) cyc();
      if (p == 4) chk("tmo_early", tx_vld, 0);
      pulse_man = 1'b1;
      cyc();
      pulse_man = 1'b0;
    end
    #1;
    chk("tmo_exact", tx_vld, 0);
    cyc(); #1;
    chk("tmo_start", tx_vld, 1);
    pulse_en = 1'b1;
    wait_idle("idle_tmo");
    chk("tmo_len", flens[$], 3);
    chk("tmo_bytes", last_nbytes, 13);

    // Overflow with the UART stalled
    txd_en = 0;
    for (int i = 0; i < 10; i++) begin
      put(7'(i), 16'($urandom));
      #1;
      if (i == 4) chk("rdy_5th", chip_rdy, 1);
      if (i == 5) chk("rdy_6th", chip_rdy, 0);
    end
    chk("ovf_set", ovf, 1);
    txd_en = 1;
    wait_idle("idle_ovf");
    chk("ovf_len", flens[$], FRM_LEN);
    chk("ovf_sticky", ovf, 1);

    // Byte backpressure with random sample traffic
    txd_max = 20;
    dev_id = 6'($urandom);
    for (int i = 0; i < 20; i++) begin
      put_rdy(7'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 4)) cyc();
    end
    wait_idle("idle_bp");

    // Mixed sel with writes while a frame is in flight
    txd_max = 3;
    pulse_en = 1'b0;
    for (int i = 0; i < FRM_LEN; i++) put(7'(1 + i % 2), 16'($urandom));
    wait_vld("mid_vld");
    for (int i = 0; i < 4; i++) put_rdy(7'(1 + i % 2), 16'($urandom));
    pulse_en = 1'b1;
    wait_idle("idle_mid");
    chk("mid_len1", flens[flens.size() - 2], FRM_LEN);
    chk("mid_len2", flens[$], 4);

    // Reset during a DHI byte
    txd_max = 2;
    for (int i = 0; i < FRM_LEN; i++) put(7'd9, 16'($urandom));
    n = 0;
    while (!(fidx >= 3 && (fidx - 3) % 3 == 1) && n < 2000) begin cyc(); n++; end
    chk("wait_dhi", (n < 2000), 1);
    rst = 1'b1;
    cyc(); #1;
    chk("rst_mid_vld", tx_vld, 0);
    chk("rst_mid_ovf", ovf, 0);
    chk("rst_mid_rdy", chip_rdy, 0);
    cyc(); #1;
    chk("rst_hold_rdy", chip_rdy, 0);
    rst = 1'b0;
    cyc(); #1;
    chk("rst_rel_rdy", chip_rdy, 1);
    chk("rst_rel_vld", tx_vld, 0);
    for (int i = 0; i < 5; i++) put(7'(i), 16'($urandom));
    wait_idle("idle_rst");
    chk("rst_len", flens[$], 5);

    // Random soak, occasionally ignoring chip_rdy to provoke drops
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 0) txd_max = $urandom_range(0, 6);
      chip_sel = 7'($urandom);
      chip_d = 16'($urandom);
      chip_vld = ($urandom_range(0, 3) == 0) && (chip_rdy || $urandom_range(0, 9) == 0);
      cyc();
    end
    chip_vld = 1'b0;
    wait_idle("idle_soak");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
